ucc_counter_sequencer: RTL and testbench

- Command-driven sequencer for a WIDTH-bit universal counter chain built from 1-bit universal counter cells.
- Owns the count register and its four-mode next-state logic: hold, increment, decrement and parallel load.
- Accepts load and count-N-steps commands over a valid/ready handshake, then issues the per-cycle mode code to the chain.
- Reports completion and wrap-around to the surrounding control logic.

---
 rtl/ucc_counter_sequencer_if.sv | 24 ++
 rtl/ucc_counter_sequencer.sv | 129 ++++++++++++
 tb/tb_ucc_counter_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ucc_counter_sequencer_if.sv
// Command handshake between a requester and the counter sequencer.
// The master drives op/arg under cmd_valid; the slave returns cmd_ready.
interface ucc_counter_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/ucc_counter_sequencer.sv
// Command-driven sequencer for a universal counter chain: accepts load / count-N commands
// and drives per-cycle hold/inc/dec/load modes into a chain of 1-bit counter cells.
module ucc_counter_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ucc_counter_sequencer_if.slave  cmd,
  output logic [WIDTH-1:0]        count,
  output logic [1:0]              mode,
  output logic                    carry_out,
  output logic                    busy,
  output logic                    done,
  output logic                    wrap
);

  localparam logic [1:0] ModeHold = 2'b00;
  localparam logic [1:0] ModeInc  = 2'b01;
  localparam logic [1:0] ModeDec  = 2'b10;
  localparam logic [1:0] ModeLoad = 2'b11;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [1:0]       dir_q, dir_d;
  logic             done_q, done_d;
  logic             wrap_q;

  logic accept;
  logic is_step_op;
  logic start_run;
  logic chain_c;

  assign accept     = cmd.cmd_valid && cmd.cmd_ready;
  assign is_step_op = (cmd.cmd_op == ModeInc) || (cmd.cmd_op == ModeDec);
  assign start_run  = accept && is_step_op && (cmd.cmd_arg != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_run) state_d = StRun;
      StRun:   if (remaining_q == WIDTH'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    mode          = ModeHold;
    cmd.cmd_ready = (state_q == StIdle);
    busy          = (state_q == StRun);
    done_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && cmd.cmd_op == ModeLoad) mode = ModeLoad;
        done_d = accept && !start_run;
      end
      StRun: begin
        mode   = dir_q;
        done_d = (remaining_q == WIDTH'(1));
      end
      default: ;
    endcase
    if (rst) mode = ModeHold;
  end

  // Cell chain: each cell toggles when its incoming carry/borrow is set; a cell propagates
  // the chain when it is 1 (inc) or 0 (dec).
  always_comb begin
    chain_c = 1'b1;
    count_d = count_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      unique case (mode)
        ModeInc, ModeDec: count_d[i] = count_q[i] ^ chain_c;
        ModeLoad:         count_d[i] = cmd.cmd_arg[i];
        default:          count_d[i] = count_q[i];
      endcase
      chain_c = chain_c & (count_q[i] ^ mode[1]);
    end
  end

  assign carry_out = (mode == ModeInc || mode == ModeDec) && chain_c;

  always_comb begin
    remaining_d = remaining_q;
    dir_d       = dir_q;
    if (state_q == StIdle) begin
      if (start_run) begin
        remaining_d = cmd.cmd_arg;
        dir_d       = cmd.cmd_op;
      end
    end else begin
      remaining_d = remaining_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      remaining_q <= '0;
      dir_q       <= ModeHold;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      wrap_q      <= carry_out;
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_ucc_counter_sequencer.sv
// Directed bench for ucc_counter_sequencer: hand-computed vectors checked with immediate
// assertions, one cycle at a time, sampled 1ns after the rising edge.
module tb_ucc_counter_sequencer;
  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] count;
  logic [1:0]       mode;
  logic             carry_out;
  logic             busy;
  logic             done;
  logic             wrap;

  int vectors = 0;
  int errors  = 0;

  ucc_counter_sequencer_if #(.WIDTH(WIDTH)) cmd_if ();

  ucc_counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .count     (count),
    .mode      (mode),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] arg);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    #1;
  endtask

  // Checks count/busy/done/wrap/carry_out in one call.
  task automatic chk_state(input string tag, input logic [7:0] c, input logic b, input logic d,
                           input logic w, input logic co);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".wrap"},  32'(wrap),  32'(w));
    chk({tag, ".carry"}, 32'(carry_out), 32'(co));
  endtask

  initial begin
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_arg   = '0;
    #2;
    chk_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.mode", 32'(mode), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset.ready", 32'(cmd_if.cmd_ready), 32'd1);

    // Load 0xA5
    drive(1'b1, 2'b11, 8'hA5);
    chk("ldA5.mode", 32'(mode), 32'd3);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    chk_state("ldA5.done", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ldA5.mode_after", 32'(mode), 32'd0);
    tick();
    chk_state("ldA5.idle", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load 0xFE then up 3, back-to-back
    drive(1'b1, 2'b11, 8'hFE);
    tick();
    chk_state("ldFE", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 8'd3);
    chk("up3.accept_mode", 32'(mode), 32'd0);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    chk_state("up3.r0", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("up3.mode", 32'(mode), 32'd1);
    chk("up3.ready", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    chk_state("up3.r1", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("up3.r2", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("up3.done", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("up3.ready_back", 32'(cmd_if.cmd_ready), 32'd1);

    // Load 0x01 then down 2
    drive(1'b1, 2'b11, 8'h01);
    tick();
    chk_state("ld01", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 8'd2);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    chk_state("dn2.r0", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dn2.mode", 32'(mode), 32'd2);
    tick();
    chk_state("dn2.r1", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("dn2.done", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);

    // Up 0, then NOP
    drive(1'b1, 2'b01, 8'd0);
    tick();
    chk_state("up0", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 8'h55);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    chk_state("nop", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_state("nop.after", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Down 5 with a load held pending during RUN
    drive(1'b1, 2'b10, 8'd5);
    tick();
    drive(1'b1, 2'b11, 8'h3C);
    chk("dn5.mode", 32'(mode), 32'd2);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i < 5) begin
        chk_state($sformatf("dn5.r%0d", i), 8'(8'hFF - i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk($sformatf("dn5.ready%0d", i), 32'(cmd_if.cmd_ready), 32'd0);
      end
    end
    chk_state("dn5.done", 8'hFA, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dn5.ld_mode", 32'(mode), 32'd3);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    chk_state("dn5.ld3C", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);

    // Up 10, reset after 4 steps
    drive(1'b1, 2'b01, 8'd10);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk_state("up10.r4", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_state("up10.rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("up10.rst_mode", 32'(mode), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state($sformatf("up10.post%0d", i), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
